// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the ARM memory stage.
//   mem_state_t : SRAM access FSM states.
//   DATA_W      : datapath width.
//   REG_ADDR_W  : register-file index width.
//   CNT_W       : wait-cycle counter width (covers WAIT_CYCLES up to 15).
//   word_offset : byte address -> word offset relative to a base address.
package mem_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } mem_state_t;

    function automatic logic [DATA_W-1:0] word_offset(input logic [DATA_W-1:0] byte_addr,
                                                      input logic [DATA_W-1:0] base_addr);
        return (byte_addr - base_addr) >> 2;
    endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: fixed-latency single-port SRAM access sequencer.
// Owns the access FSM, wait counter, address/write-data latches and the
// registered load data. Stalls the pipeline through freeze_o while busy.
//
// Optional build macro: MEM_ALIGN_CHECK_EN adds align_err_o and suppresses
// accesses whose byte address is not word aligned.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   rd_req_i       : load request
//   wr_req_i       : store request (wins over rd_req_i)
//   addr_i         : effective byte address
//   wdata_i        : store data
//   sram_rdata_i   : SRAM read data
//   sram_addr_o    : SRAM word address
//   sram_wdata_o   : SRAM write data
//   sram_we_o      : SRAM write strobe
//   sram_re_o      : SRAM read strobe
//   freeze_o       : pipeline stall request
//   rdata_o        : registered load data
//   align_err_o    : misaligned request flag (MEM_ALIGN_CHECK_EN only)
module sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned      WAIT_CYCLES = 4,
    parameter logic [31:0]      BASE_ADDR   = 32'd1024,
    parameter int unsigned      ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_i,
    input  logic              wr_req_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] sram_rdata_i,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic              sram_we_o,
    output logic              sram_re_o,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              align_err_o,
`endif
    output logic              freeze_o,
    output logic [DATA_W-1:0] rdata_o
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gen_bad_wait_cycles
        $error("sram_ctrl: WAIT_CYCLES must be in 1..15");
    end

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              req;
    logic              issue;
    logic [ADDR_W-1:0] addr_word;

    assign req       = rd_req_i | wr_req_i;
    assign addr_word = ADDR_W'(word_offset(addr_i, BASE_ADDR));

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |addr_i[1:0];
    assign issue      = req & ~misaligned;
`else
    // Low address bits are simply dropped by the word conversion.
    assign issue      = req;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        re_d     = re_q;
        rdata_d  = rdata_q;
        freeze_o = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        align_err_o = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                // Stall the same cycle the request arrives so upstream holds it.
                freeze_o = issue;
                if (issue) begin
                    addr_d  = addr_word;
                    wdata_d = wdata_i;
                    we_d    = wr_req_i;
                    re_d    = rd_req_i & ~wr_req_i;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCESS;
                end
`ifdef MEM_ALIGN_CHECK_EN
                if (req && misaligned) begin
                    align_err_o = 1'b1;
                    rdata_d     = '0;
                end
`endif
            end
            ACCESS: begin
                freeze_o = 1'b1;
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    if (re_q) begin
                        rdata_d = sram_rdata_i;
                    end
                    we_d    = 1'b0;
                    re_d    = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Upstream advances at this edge; the stale instruction still
                // on the inputs must not be re-issued, so return to IDLE blindly.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            re_q    <= re_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;
    assign sram_we_o    = we_q;
    assign sram_re_o    = re_q;
    assign rdata_o      = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 32-bit ARM pipeline. Issues loads/stores to
// a fixed-latency SRAM via sram_ctrl, stalls upstream with FREEZE while an
// access is in flight and forwards write-back controls to the MEM/WB register.
//
// Optional build macro: MEM_ALIGN_CHECK_EN adds ALIGN_ERR; misaligned memory
// requests are dropped and their write-back is suppressed.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   WB_EN_IN      : write-back enable from EXE/MEM
//   MEM_R_EN_IN   : load request
//   MEM_W_EN_IN   : store request
//   ALU_RES_IN    : effective byte address or ALU result
//   VAL_RM_IN     : store data
//   DEST_IN       : destination register
//   SRAM_RDATA    : SRAM read data
//   WB_EN_OUT     : write-back enable to MEM/WB (masked while stalled)
//   MEM_R_EN_OUT  : load select at write-back (pass-through)
//   ALU_RES_OUT   : ALU result (pass-through)
//   MEM_RES_OUT   : registered load data
//   DEST_OUT      : destination register (pass-through)
//   FREEZE        : pipeline stall request
//   SRAM_*        : SRAM word address, write data, write/read strobes
//   ALIGN_ERR     : misaligned request flag (MEM_ALIGN_CHECK_EN only)
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 4,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_EN_IN,
    input  logic                  MEM_R_EN_IN,
    input  logic                  MEM_W_EN_IN,
    input  logic [DATA_W-1:0]     ALU_RES_IN,
    input  logic [DATA_W-1:0]     VAL_RM_IN,
    input  logic [REG_ADDR_W-1:0] DEST_IN,
    input  logic [DATA_W-1:0]     SRAM_RDATA,
    output logic                  WB_EN_OUT,
    output logic                  MEM_R_EN_OUT,
    output logic [DATA_W-1:0]     ALU_RES_OUT,
    output logic [DATA_W-1:0]     MEM_RES_OUT,
    output logic [REG_ADDR_W-1:0] DEST_OUT,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  ALIGN_ERR,
`endif
    output logic                  FREEZE,
    output logic [ADDR_W-1:0]     SRAM_ADDR,
    output logic [DATA_W-1:0]     SRAM_WDATA,
    output logic                  SRAM_WE,
    output logic                  SRAM_RE
);

    sram_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .BASE_ADDR   (BASE_ADDR),
        .ADDR_W      (ADDR_W)
    ) u_sram_ctrl (
        .clk          (clk),
        .rst          (rst),
        .rd_req_i     (MEM_R_EN_IN),
        .wr_req_i     (MEM_W_EN_IN),
        .addr_i       (ALU_RES_IN),
        .wdata_i      (VAL_RM_IN),
        .sram_rdata_i (SRAM_RDATA),
        .sram_addr_o  (SRAM_ADDR),
        .sram_wdata_o (SRAM_WDATA),
        .sram_we_o    (SRAM_WE),
        .sram_re_o    (SRAM_RE),
`ifdef MEM_ALIGN_CHECK_EN
        .align_err_o  (ALIGN_ERR),
`endif
        .freeze_o     (FREEZE),
        .rdata_o      (MEM_RES_OUT)
    );

    // Write-back is only released once the access has completed.
`ifdef MEM_ALIGN_CHECK_EN
    assign WB_EN_OUT = WB_EN_IN & ~FREEZE & ~ALIGN_ERR;
`else
    assign WB_EN_OUT = WB_EN_IN & ~FREEZE;
`endif

    assign MEM_R_EN_OUT = MEM_R_EN_IN;
    assign ALU_RES_OUT  = ALU_RES_IN;
    assign DEST_OUT     = DEST_IN;

endmodule
